// File: rtl/mult_control.sv
// Moore sequencer for the shift-add multiply datapath: LOAD for one cycle, RUN once per multiplier bit, then DONE until acknowledged.
// Outputs decode from the state register only; an internal iteration count bounds RUN independently of the datapath's stop flag.
module mult_control #(
  parameter int ITERATIONS = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clock_sign,
  input  logic             reset_sign,
  input  logic             start_req,
  input  logic             abort_req,
  input  logic             stop,
  input  logic             done_ack,
  output logic             start_mult_sign,
  output logic             multipliar_sign,
  output logic             product_sign,
  output logic             count_sign,
  output logic             busy,
  output logic             done,
  output logic             stop_mismatch,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             mism_q, mism_d;
  logic             at_last;

  assign at_last = (iter_q == LAST_ITER);

  always_ff @(posedge clock_sign or negedge reset_sign) begin
    if (!reset_sign) begin
      state_q <= IDLE;
      iter_q  <= '0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mism_q  <= mism_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mism_d  = mism_q;
    if (abort_req && (state_q != IDLE)) begin
      state_d = IDLE;
      iter_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_req && !abort_req) state_d = LOAD;
        end
        LOAD: begin
          iter_d  = '0;
          state_d = RUN;
        end
        RUN: begin
          // Datapath stop must coincide exactly with our own final count.
          if (stop != at_last) mism_d = 1'b1;
          if (stop || at_last) state_d = DONE;
          else                 iter_d  = iter_q + CNT_W'(1);
        end
        DONE: begin
          if (done_ack) begin
            state_d = IDLE;
            iter_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    start_mult_sign = 1'b0;
    multipliar_sign = 1'b0;
    product_sign    = 1'b0;
    count_sign      = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state_q)
      LOAD: begin
        start_mult_sign = 1'b1;
        multipliar_sign = 1'b1;
        busy            = 1'b1;
      end
      RUN: begin
        multipliar_sign = 1'b1;
        product_sign    = 1'b1;
        count_sign      = 1'b1;
        busy            = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign stop_mismatch = mism_q;
  assign iter_count    = iter_q;

endmodule
